// File: rtl/frame_diff_motion_detect_if.sv
// Video stream, configuration and statistics bundle for the frame-difference motion stage.
// The master drives the live/previous luma stream and the thresholds; the slave returns the aligned result.
interface frame_diff_motion_detect_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 20
);
  logic              per_frame_vsync;
  logic              per_frame_href;
  logic              per_frame_clken;
  logic [DATA_W-1:0] per_img_Y;
  logic [DATA_W-1:0] pre_img_Y;
  logic [DATA_W-1:0] diff_threshold;
  logic [1:0]        diff_mode;
  logic [CNT_W-1:0]  motion_threshold;

  logic              post_frame_vsync;
  logic              post_frame_href;
  logic              post_frame_clken;
  logic              post_img_Bit;
  logic [DATA_W-1:0] post_img_diff;
  logic [CNT_W-1:0]  motion_count;
  logic              motion_flag;
  logic              warm;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y, pre_img_Y,
           diff_threshold, diff_mode, motion_threshold,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
           post_img_diff, motion_count, motion_flag, warm
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y, pre_img_Y,
           diff_threshold, diff_mode, motion_threshold,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
           post_img_diff, motion_count, motion_flag, warm
  );
endinterface

// File: rtl/frame_diff_motion_detect.sv
// Frame-difference motion detector: per-pixel |cur-pre| and motion bit, per-frame changed-pixel
// count with a latched frame motion flag, gated by a warm-up period after reset.
module frame_diff_motion_detect #(
  parameter int DATA_W        = 8,
  parameter int PRE_LAT       = 1,
  parameter int CNT_W         = 20,
  parameter int WARMUP_FRAMES = 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  frame_diff_motion_detect_if.slave io
);

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sideband_t;

  localparam logic [3:0] WARM_MAX = 4'(WARMUP_FRAMES);

  sideband_t         sb_q  [PRE_LAT+1];
  logic [DATA_W-1:0] cur_q [PRE_LAT];

  // NOTE: sequential state is always written with <= so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // NOTE: the delay lines are reset so no stale clken/vsync can leak out as a phantom
      // pixel or frame edge right after reset.
      for (int i = 0; i <= PRE_LAT; i++) sb_q[i] <= '0;
      for (int i = 0; i < PRE_LAT; i++) cur_q[i] <= '0;
    end else begin
      sb_q[0] <= sideband_t'{vsync: io.per_frame_vsync,
                             href:  io.per_frame_href,
                             clken: io.per_frame_clken};
      for (int i = 1; i <= PRE_LAT; i++) sb_q[i] <= sb_q[i-1];
      cur_q[0] <= io.per_img_Y;
      for (int i = 1; i < PRE_LAT; i++) cur_q[i] <= cur_q[i-1];
    end
  end

  logic [DATA_W-1:0] cur_al;
  logic [DATA_W-1:0] d_nxt;
  logic              cur_gt;
  logic              pre_gt;
  logic              over;
  logic              bit_nxt;

  // Subtraction is ordered by the magnitude compare, so it never wraps.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cur_al  = cur_q[PRE_LAT-1];
    cur_gt  = cur_al > io.pre_img_Y;
    pre_gt  = io.pre_img_Y > cur_al;
    d_nxt   = cur_gt ? (cur_al - io.pre_img_Y) : (io.pre_img_Y - cur_al);
    over    = d_nxt > io.diff_threshold;
    bit_nxt = over;
    case (io.diff_mode)
      2'd1:    bit_nxt = cur_gt & over;
      2'd2:    bit_nxt = pre_gt & over;
      default: bit_nxt = over;
    endcase
  end

  logic [DATA_W-1:0] diff_q;
  logic              bit_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      diff_q <= '0;
      bit_q  <= 1'b0;
    end else if (sb_q[PRE_LAT-1].clken) begin
      diff_q <= d_nxt;
      bit_q  <= bit_nxt;
    end
  end

  sideband_t        post_sb;
  logic             vs_q;
  logic             frame_start;
  logic             frame_end;
  logic [3:0]       warm_cnt;
  logic             warm_at_start;
  logic             warm_now;
  logic             bit_out;
  logic             inc;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W:0]   acc_sum;
  logic [CNT_W-1:0] acc_sat;
  logic [CNT_W-1:0] count_q;
  logic             flag_q;

  assign post_sb     = sb_q[PRE_LAT];
  assign frame_start = post_sb.vsync & ~vs_q;
  assign frame_end   = ~post_sb.vsync & vs_q;
  assign warm_now    = (warm_cnt == WARM_MAX);
  assign bit_out     = post_sb.href & bit_q & warm_now;
  assign inc         = post_sb.clken & bit_out;
  assign acc_sum     = {1'b0, acc_q} + (CNT_W+1)'(inc);
  assign acc_sat     = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];

  // A pixel landing on the frame-end cycle is still folded into that frame's count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_q          <= 1'b0;
      warm_cnt      <= '0;
      warm_at_start <= 1'b0;
      acc_q         <= '0;
      count_q       <= '0;
      flag_q        <= 1'b0;
    end else begin
      vs_q <= post_sb.vsync;
      if (frame_start) begin
        acc_q         <= CNT_W'(inc);
        warm_at_start <= warm_now;
      end else begin
        acc_q <= acc_sat;
      end
      if (frame_end) begin
        count_q <= acc_sat;
        flag_q  <= warm_at_start && (acc_sat > io.motion_threshold);
        if (!warm_now) warm_cnt <= warm_cnt + 4'd1;
      end
    end
  end

  assign io.post_frame_vsync = post_sb.vsync;
  assign io.post_frame_href  = post_sb.href;
  assign io.post_frame_clken = post_sb.clken;
  assign io.post_img_Bit     = bit_out;
  assign io.post_img_diff    = post_sb.href ? diff_q : '0;
  assign io.motion_count     = count_q;
  assign io.motion_flag      = flag_q;
  assign io.warm             = warm_now;

endmodule

// File: tb/tb_frame_diff_motion_detect.sv
// Bench for frame_diff_motion_detect: two instances (PRE_LAT=1/CNT_W=20 and PRE_LAT=4/CNT_W=4)
// share one stimulus stream; per-pixel results are scoreboarded, frame statistics checked per frame.
module tb_frame_diff_motion_detect;

  localparam int DW    = 8;
  localparam int LAT_A = 1;
  localparam int LAT_B = 4;
  localparam int CW_A  = 20;
  localparam int CW_B  = 4;
  localparam int WU    = 1;
  localparam int MAX_B = (1 << CW_B) - 1;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  frame_diff_motion_detect_if #(.DATA_W(DW), .CNT_W(CW_A)) if_a ();
  frame_diff_motion_detect_if #(.DATA_W(DW), .CNT_W(CW_B)) if_b ();

  frame_diff_motion_detect #(
    .DATA_W(DW), .PRE_LAT(LAT_A), .CNT_W(CW_A), .WARMUP_FRAMES(WU)
  ) u_a (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .io       (if_a)
  );

  frame_diff_motion_detect #(
    .DATA_W(DW), .PRE_LAT(LAT_B), .CNT_W(CW_B), .WARMUP_FRAMES(WU)
  ) u_b (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .io       (if_b)
  );

  typedef struct {
    logic [DW-1:0] diff;
    logic          motion;
    int            t;
  } exp_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t          q_a[$];
  exp_t          q_b[$];
  logic [DW-1:0] px_cur[$];
  logic [DW-1:0] px_pre[$];
  logic [DW-1:0] pre_hist[8];

  logic warm_m;
  logic warm_start_m;
  int   frames_done;
  int   cnt_a;
  int   cnt_b;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic int model_diff(input logic [DW-1:0] c, input logic [DW-1:0] p);
    return (c > p) ? (int'(c) - int'(p)) : (int'(p) - int'(c));
  endfunction

  function automatic logic model_bit(input logic [DW-1:0] c, input logic [DW-1:0] p,
                                     input logic [DW-1:0] thr, input logic [1:0] mode);
    logic over;
    over = model_diff(c, p) > int'(thr);
    case (mode)
      2'd1:    return (c > p) && over;
      2'd2:    return (p > c) && over;
      default: return over;
    endcase
  endfunction

  // Scoreboard pop/compare for each instance, sampled 1 time unit after the active edge.
  exp_t ea;
  always @(posedge sys_clk) begin
    #1;
    if (if_a.post_frame_href && if_a.post_frame_clken) begin
      n_cmp++;
      if (q_a.size() == 0) begin
        n_err++;
        $display("FAIL a_unexpected_pixel: got diff=%0d bit=%b, expected no pixel",
                 if_a.post_img_diff, if_a.post_img_Bit);
      end else begin
        ea = q_a.pop_front();
        if (if_a.post_img_diff !== ea.diff || if_a.post_img_Bit !== ea.motion ||
            (cyc - ea.t) != LAT_A + 1) begin
          n_err++;
          $display("FAIL a_pixel: got diff=%0d bit=%b lat=%0d, expected diff=%0d bit=%b lat=%0d",
                   if_a.post_img_diff, if_a.post_img_Bit, cyc - ea.t, ea.diff, ea.motion, LAT_A + 1);
        end
      end
    end else if (!if_a.post_frame_href) begin
      n_cmp++;
      if (if_a.post_img_diff !== '0 || if_a.post_img_Bit !== 1'b0) begin
        n_err++;
        $display("FAIL a_blank_zero: got diff=%0d bit=%b, expected 0/0",
                 if_a.post_img_diff, if_a.post_img_Bit);
      end
    end
  end

  exp_t eb;
  always @(posedge sys_clk) begin
    #1;
    if (if_b.post_frame_href && if_b.post_frame_clken) begin
      n_cmp++;
      if (q_b.size() == 0) begin
        n_err++;
        $display("FAIL b_unexpected_pixel: got diff=%0d bit=%b, expected no pixel",
                 if_b.post_img_diff, if_b.post_img_Bit);
      end else begin
        eb = q_b.pop_front();
        if (if_b.post_img_diff !== eb.diff || if_b.post_img_Bit !== eb.motion ||
            (cyc - eb.t) != LAT_B + 1) begin
          n_err++;
          $display("FAIL b_pixel: got diff=%0d bit=%b lat=%0d, expected diff=%0d bit=%b lat=%0d",
                   if_b.post_img_diff, if_b.post_img_Bit, cyc - eb.t, eb.diff, eb.motion, LAT_B + 1);
        end
      end
    end else if (!if_b.post_frame_href) begin
      n_cmp++;
      if (if_b.post_img_diff !== '0 || if_b.post_img_Bit !== 1'b0) begin
        n_err++;
        $display("FAIL b_blank_zero: got diff=%0d bit=%b, expected 0/0",
                 if_b.post_img_diff, if_b.post_img_Bit);
      end
    end
  end

  // One clock of stimulus; the previous-frame luma reaches each instance PRE_LAT cycles late.
  task automatic drive_cycle(input logic vs, input logic hs, input logic ck,
                             input logic [DW-1:0] cur, input logic [DW-1:0] pre);
    exp_t e;
    @(posedge sys_clk);
    #1;
    for (int i = 7; i > 0; i--) pre_hist[i] = pre_hist[i-1];
    pre_hist[0] = pre;
    if_a.per_frame_vsync = vs;  if_b.per_frame_vsync = vs;
    if_a.per_frame_href  = hs;  if_b.per_frame_href  = hs;
    if_a.per_frame_clken = ck;  if_b.per_frame_clken = ck;
    if_a.per_img_Y       = cur; if_b.per_img_Y       = cur;
    if_a.pre_img_Y = pre_hist[LAT_A];
    if_b.pre_img_Y = pre_hist[LAT_B];
    if (hs && ck) begin
      e.diff   = DW'(model_diff(cur, pre));
      e.motion = warm_m && model_bit(cur, pre, if_a.diff_threshold, if_a.diff_mode);
      e.t      = cyc;
      q_a.push_back(e);
      q_b.push_back(e);
      if (e.motion) begin
        cnt_a++;
        if (cnt_b < MAX_B) cnt_b++;
      end
    end
  endtask

  task automatic set_cfg(input logic [DW-1:0] thr, input logic [1:0] mode,
                         input int mt_a, input int mt_b);
    if_a.diff_threshold = thr;  if_b.diff_threshold = thr;
    if_a.diff_mode      = mode; if_b.diff_mode      = mode;
    if_a.motion_threshold = CW_A'(mt_a);
    if_b.motion_threshold = CW_B'(mt_b);
  endtask

  // Full frame from px_cur/px_pre, then frame statistics of both instances.
  task automatic run_frame(input string tag, input int lines, input int pix, input bit last_at_fall);
    int   idx;
    bit   last;
    logic exp_fa;
    logic exp_fb;
    cnt_a = 0;
    cnt_b = 0;
    warm_start_m = warm_m;
    repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, '0, '0);
    for (int l = 0; l < lines; l++) begin
      for (int i = 0; i < pix; i++) begin
        idx  = l * pix + i;
        last = (l == lines - 1) && (i == pix - 1);
        drive_cycle(!(last_at_fall && last), 1'b1, 1'b1, px_cur[idx], px_pre[idx]);
      end
      if (!(last_at_fall && l == lines - 1)) repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, '0, '0);
    end
    repeat (8) drive_cycle(1'b0, 1'b0, 1'b0, '0, '0);
    frames_done++;
    warm_m = (frames_done >= WU);
    exp_fa = warm_start_m && (cnt_a > int'(if_a.motion_threshold));
    exp_fb = warm_start_m && (cnt_b > int'(if_b.motion_threshold));

    n_cmp++;
    if (if_a.motion_count !== CW_A'(cnt_a)) begin
      n_err++;
      $display("FAIL %s a_count: got %0d, expected %0d", tag, if_a.motion_count, cnt_a);
    end
    n_cmp++;
    if (if_a.motion_flag !== exp_fa) begin
      n_err++;
      $display("FAIL %s a_flag: got %b, expected %b", tag, if_a.motion_flag, exp_fa);
    end
    n_cmp++;
    if (if_a.warm !== warm_m) begin
      n_err++;
      $display("FAIL %s a_warm: got %b, expected %b", tag, if_a.warm, warm_m);
    end
    n_cmp++;
    if (if_b.motion_count !== CW_B'(cnt_b)) begin
      n_err++;
      $display("FAIL %s b_count: got %0d, expected %0d", tag, if_b.motion_count, cnt_b);
    end
    n_cmp++;
    if (if_b.motion_flag !== exp_fb) begin
      n_err++;
      $display("FAIL %s b_flag: got %b, expected %b", tag, if_b.motion_flag, exp_fb);
    end
    n_cmp++;
    if (if_b.warm !== warm_m) begin
      n_err++;
      $display("FAIL %s b_warm: got %b, expected %b", tag, if_b.warm, warm_m);
    end
  endtask

  task automatic test_reset();
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, '0, '0);
    n_cmp++;
    if ({if_a.post_frame_vsync, if_a.post_frame_href, if_a.post_frame_clken, if_a.post_img_Bit,
         if_a.post_img_diff, if_a.motion_count, if_a.motion_flag, if_a.warm} !== '0) begin
      n_err++;
      $display("FAIL reset_a_outputs: got vs=%b hs=%b ck=%b bit=%b diff=%0d cnt=%0d flag=%b warm=%b, expected all 0",
               if_a.post_frame_vsync, if_a.post_frame_href, if_a.post_frame_clken, if_a.post_img_Bit,
               if_a.post_img_diff, if_a.motion_count, if_a.motion_flag, if_a.warm);
    end
    n_cmp++;
    if ({if_b.post_frame_vsync, if_b.post_frame_href, if_b.post_frame_clken, if_b.post_img_Bit,
         if_b.post_img_diff, if_b.motion_count, if_b.motion_flag, if_b.warm} !== '0) begin
      n_err++;
      $display("FAIL reset_b_outputs: got vs=%b hs=%b ck=%b bit=%b diff=%0d cnt=%0d flag=%b warm=%b, expected all 0",
               if_b.post_frame_vsync, if_b.post_frame_href, if_b.post_frame_clken, if_b.post_img_Bit,
               if_b.post_img_diff, if_b.motion_count, if_b.motion_flag, if_b.warm);
    end
    sys_rst_n = 1'b1;
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_warmup();
    set_cfg(8'd10, 2'd0, 0, 0);
    px_cur.delete(); px_pre.delete();
    for (int i = 0; i < 16; i++) begin
      px_cur.push_back(8'd200);
      px_pre.push_back(8'(i * 3));
    end
    n_cmp++;
    if (if_b.warm !== 1'b0) begin
      n_err++;
      $display("FAIL warmup_before: got warm=%b, expected 0", if_b.warm);
    end
    run_frame("warmup", 2, 8, 1'b0);
  endtask

  task automatic test_modes();
    logic [DW-1:0] cv[7] = '{8'd200, 8'd100, 8'd150, 8'd151, 8'd0, 8'd255, 8'd100};
    logic [DW-1:0] pv[7] = '{8'd100, 8'd200, 8'd100, 8'd100, 8'd255, 8'd0, 8'd150};
    for (int m = 0; m < 4; m++) begin
      set_cfg(8'd50, 2'(m), 3, 3);
      px_cur.delete(); px_pre.delete();
      for (int i = 0; i < 7; i++) begin
        px_cur.push_back(cv[i]);
        px_pre.push_back(pv[i]);
      end
      run_frame($sformatf("mode%0d", m), 1, 7, 1'b0);
    end
  endtask

  task automatic fill_64x4(input int n_diff);
    px_cur.delete(); px_pre.delete();
    for (int i = 0; i < 256; i++) begin
      px_pre.push_back(8'(i % 100));
      if ((i % 7 == 0) && (i / 7 < n_diff)) px_cur.push_back(8'(i % 100 + 80));
      else                                   px_cur.push_back(8'(i % 100));
    end
  endtask

  task automatic test_count_threshold();
    fill_64x4(37);
    set_cfg(8'd50, 2'd0, 36, 14);
    run_frame("cnt37_thr36", 4, 64, 1'b0);
    set_cfg(8'd50, 2'd0, 37, 15);
    run_frame("cnt37_thr37", 4, 64, 1'b0);
    fill_64x4(36);
    set_cfg(8'd50, 2'd0, 36, 15);
    run_frame("cnt36_thr36", 4, 64, 1'b0);
  endtask

  task automatic test_saturation_last();
    px_cur.delete(); px_pre.delete();
    for (int i = 0; i < 24; i++) begin
      px_pre.push_back(8'd40);
      px_cur.push_back(i >= 4 ? 8'd140 : 8'd40);
    end
    set_cfg(8'd50, 2'd0, 19, 14);
    run_frame("sat_last_at_fall", 1, 24, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    set_cfg(8'd20, 2'd0, 0, 0);
    repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b1, 1'b1, 8'd230, 8'd30);
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if_a.post_frame_vsync, if_a.post_frame_href, if_a.post_frame_clken, if_a.post_img_Bit,
         if_a.post_img_diff, if_a.motion_count, if_a.motion_flag, if_a.warm} !== '0) begin
      n_err++;
      $display("FAIL midreset_a_outputs: got vs=%b hs=%b bit=%b diff=%0d cnt=%0d flag=%b warm=%b, expected all 0",
               if_a.post_frame_vsync, if_a.post_frame_href, if_a.post_img_Bit, if_a.post_img_diff,
               if_a.motion_count, if_a.motion_flag, if_a.warm);
    end
    n_cmp++;
    if ({if_b.post_frame_vsync, if_b.post_frame_href, if_b.post_frame_clken, if_b.post_img_Bit,
         if_b.post_img_diff, if_b.motion_count, if_b.motion_flag, if_b.warm} !== '0) begin
      n_err++;
      $display("FAIL midreset_b_outputs: got vs=%b hs=%b bit=%b diff=%0d cnt=%0d flag=%b warm=%b, expected all 0",
               if_b.post_frame_vsync, if_b.post_frame_href, if_b.post_img_Bit, if_b.post_img_diff,
               if_b.motion_count, if_b.motion_flag, if_b.warm);
    end
    q_a.delete();
    q_b.delete();
    warm_m      = 1'b0;
    frames_done = 0;
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, '0, '0);
    sys_rst_n = 1'b1;
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, '0, '0);
    n_cmp++;
    if (if_a.warm !== 1'b0 || if_b.warm !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_warm: got a=%b b=%b, expected 0/0", if_a.warm, if_b.warm);
    end
    px_cur.delete(); px_pre.delete();
    for (int i = 0; i < 12; i++) begin
      px_cur.push_back(8'd230);
      px_pre.push_back(8'(i));
    end
    run_frame("after_reset_warmup", 1, 12, 1'b0);
    run_frame("after_reset_live", 1, 12, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) pre_hist[i] = '0;
    warm_m      = 1'b0;
    frames_done = 0;
    cnt_a       = 0;
    cnt_b       = 0;
    if_a.per_frame_vsync = 1'b0; if_b.per_frame_vsync = 1'b0;
    if_a.per_frame_href  = 1'b0; if_b.per_frame_href  = 1'b0;
    if_a.per_frame_clken = 1'b0; if_b.per_frame_clken = 1'b0;
    if_a.per_img_Y       = '0;   if_b.per_img_Y       = '0;
    if_a.pre_img_Y       = '0;   if_b.pre_img_Y       = '0;
    set_cfg('0, 2'd0, 0, 0);

    test_reset();
    test_warmup();
    test_modes();
    test_count_threshold();
    test_saturation_last();
    test_reset_mid_frame();

    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, '0, '0);
    n_cmp++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d/%0d pending entries, expected 0/0", q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
